// File: rtl/lsu_bus_master.sv
// Load/store unit bus master: one outstanding access, byte-lane steering on the way
// out, lane extraction and sign/zero extension on the way back, bounded wait for data.
module lsu_bus_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_store_i,
    input  logic [2:0]  req_op_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_misalign_o,
    output logic        resp_timeout_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] OP_W   = 3'b000;
    localparam logic [2:0] OP_SH  = 3'b001;
    localparam logic [2:0] OP_SB  = 3'b010;
    localparam logic [2:0] OP_LH  = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [2:0] OP_LB  = 3'b110;
    localparam logic [2:0] OP_LBU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    // Ops that make no sense for the direction collapse to a word access.
    function automatic logic [2:0] norm_op(input logic store, input logic [2:0] op);
        logic [2:0] r;
        r = OP_W;
        if (store) begin
            if (op == OP_SH || op == OP_SB) r = op;
        end else begin
            if (op[2]) r = op;
        end
        return r;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] a);
        logic r;
        case (op)
            OP_SH, OP_LH, OP_LHU: r = a[0];
            OP_SB, OP_LB, OP_LBU: r = 1'b0;
            default:              r = (a != 2'b00);
        endcase
        return r;
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] op, input logic [1:0] a);
        logic [3:0] r;
        case (op)
            OP_SH, OP_LH, OP_LHU: r = a[1] ? 4'b1100 : 4'b0011;
            OP_SB, OP_LB, OP_LBU: r = 4'b0001 << a;
            default:              r = 4'b1111;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] op, input logic [31:0] wd);
        logic [31:0] r;
        case (op)
            OP_SB:   r = {4{wd[7:0]}};
            OP_SH:   r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] a,
                                                input logic [31:0] word);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] ext;
        b = word[{a, 3'b000} +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   ext = b;
            OP_LBU:  ext = {24'd0, b};
            OP_LH:   ext = h;
            OP_LHU:  ext = {16'd0, h};
            default: ext = word;
        endcase
        return ext;
    endfunction

    state_t           state, state_n;
    logic [CNT_W-1:0] wait_cnt;

    logic             store_p0;
    logic [2:0]       op_p0;
    logic [31:0]      addr_p0;
    logic [3:0]       be_p0;
    logic [31:0]      wdata_p0;

    logic [31:0]      rdata_p1;
    logic             misalign_p1;
    logic             timeout_p1;

    logic [2:0]       op_in;
    logic             mis_in;
    logic             accept;
    logic             timeout_hit;

    assign op_in  = norm_op(req_store_i, req_op_i);
    assign mis_in = is_misaligned(op_in, req_addr_i[1:0]);

    always_comb begin
        state_n     = state;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid_i) begin
                    accept  = 1'b1;
                    state_n = mis_in ? RESP : REQ;
                end
            end
            REQ: begin
                if (bus_gnt_i) state_n = WAIT;
            end
            WAIT: begin
                if (bus_rvalid_i) begin
                    state_n = RESP;
                end else if (wait_cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_n     = RESP;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            store_p0    <= 1'b0;
            op_p0       <= 3'b000;
            addr_p0     <= 32'd0;
            be_p0       <= 4'd0;
            wdata_p0    <= 32'd0;
            rdata_p1    <= 32'd0;
            misalign_p1 <= 1'b0;
            timeout_p1  <= 1'b0;
        end else begin
            state <= state_n;
            // Request capture: lanes and data are steered once, then held stable on the bus.
            if (accept) begin
                store_p0    <= req_store_i;
                op_p0       <= op_in;
                addr_p0     <= req_addr_i;
                be_p0       <= lane_be(op_in, req_addr_i[1:0]);
                wdata_p0    <= req_store_i ? lane_wdata(op_in, req_wdata_i) : 32'd0;
                rdata_p1    <= 32'd0;
                misalign_p1 <= mis_in;
                timeout_p1  <= 1'b0;
            end
            if (state == REQ && bus_gnt_i) wait_cnt <= '0;
            // Response capture: extraction happens as the word arrives.
            if (state == WAIT) begin
                if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + 1'b1;
                if (bus_rvalid_i) begin
                    rdata_p1 <= store_p0 ? 32'd0 : load_extend(op_p0, addr_p0[1:0], bus_rdata_i);
                end else if (timeout_hit) begin
                    timeout_p1 <= 1'b1;
                end
            end
        end
    end

    assign req_ready_o     = (state == IDLE);
    assign bus_req_o       = (state == REQ);
    assign bus_we_o        = bus_req_o & store_p0;
    assign bus_addr_o      = bus_req_o ? {addr_p0[31:2], 2'b00} : 32'd0;
    assign bus_be_o        = bus_req_o ? be_p0 : 4'd0;
    assign bus_wdata_o     = bus_req_o ? wdata_p0 : 32'd0;
    assign resp_valid_o    = (state == RESP);
    assign resp_rdata_o    = resp_valid_o ? rdata_p1 : 32'd0;
    assign resp_misalign_o = resp_valid_o & misalign_p1;
    assign resp_timeout_o  = resp_valid_o & timeout_p1;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Bench for lsu_bus_master: directed scenarios plus random accesses against a
// size/offset-based reference model of the load/store rules.
module tb_lsu_bus_master;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_store_i;
    logic [2:0]  req_op_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_misalign_o;
    logic        resp_timeout_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    int total = 0;
    int bad   = 0;

    lsu_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_store_i    (req_store_i),
        .req_op_i       (req_op_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .resp_valid_o   (resp_valid_o),
        .resp_rdata_o   (resp_rdata_o),
        .resp_misalign_o(resp_misalign_o),
        .resp_timeout_o (resp_timeout_o),
        .bus_req_o      (bus_req_o),
        .bus_we_o       (bus_we_o),
        .bus_addr_o     (bus_addr_o),
        .bus_be_o       (bus_be_o),
        .bus_wdata_o    (bus_wdata_o),
        .bus_gnt_i      (bus_gnt_i),
        .bus_rvalid_i   (bus_rvalid_i),
        .bus_rdata_i    (bus_rdata_i)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=no-finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Access described by size in bytes and byte offset within the word.
    function automatic void model(input logic st, input logic [2:0] op, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [31:0] raw,
                                  output logic mis, output logic [3:0] be,
                                  output logic [31:0] bw, output logic [31:0] rdat);
        int          size;
        bit          sgn;
        int          off;
        int          bits;
        logic [31:0] mask;
        logic [31:0] v;
        size = 4;
        sgn  = 1'b0;
        if (st) begin
            if (op == 3'b001) size = 2;
            else if (op == 3'b010) size = 1;
        end else begin
            case (op)
                3'b100: begin size = 2; sgn = 1'b1; end
                3'b101: size = 2;
                3'b110: begin size = 1; sgn = 1'b1; end
                3'b111: size = 1;
                default: size = 4;
            endcase
        end
        off  = int'(addr % 4);
        mis  = (off % size) != 0;
        bits = ((1 << size) - 1) << off;
        be   = 4'(bits);
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        if (size == 1)      bw = (wd & 32'hFF) * 32'h0101_0101;
        else if (size == 2) bw = (wd & 32'hFFFF) * 32'h0001_0001;
        else                bw = wd;
        v = (raw >> (8 * off)) & mask;
        if (sgn && v[8 * size - 1]) v = v | ~mask;
        rdat = st ? 32'd0 : v;
    endfunction

    // Runs one access from IDLE; gd = cycles gnt is withheld, rd = WAIT cycle carrying rvalid.
    task automatic run_access(input logic st, input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] raw,
                              input int gd, input int rd,
                              output logic [31:0] o_addr, output logic [31:0] o_be,
                              output logic [31:0] o_wd, output logic [31:0] o_rdata);
        logic        mis;
        logic [3:0]  be;
        logic [31:0] bw;
        logic [31:0] erd;
        logic        tmo;
        int          nwait;
        model(st, op, addr, wd, raw, mis, be, bw, erd);
        tmo    = !mis && (rd >= TO);
        nwait  = (rd < TO) ? rd + 1 : TO;
        o_addr = 32'd0;
        o_be   = 32'd0;
        o_wd   = 32'd0;
        chk("idle_ready", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1;
        req_store_i = st;
        req_op_i    = op;
        req_addr_i  = addr;
        req_wdata_i = wd;
        step;
        req_valid_i = 1'b0;
        req_wdata_i = $urandom;
        if (!mis) begin
            for (int i = 0; i <= gd; i++) begin
                chk("req_bus_req", 32'(bus_req_o), 32'd1);
                chk("req_not_ready", 32'(req_ready_o), 32'd0);
                chk("req_addr", bus_addr_o, {addr[31:2], 2'b00});
                chk("req_we", 32'(bus_we_o), 32'(st));
                chk("req_be", 32'(bus_be_o), 32'(be));
                if (st) chk("req_wdata", bus_wdata_o, bw);
                o_addr       = bus_addr_o;
                o_be         = 32'(bus_be_o);
                o_wd         = bus_wdata_o;
                bus_gnt_i    = (i == gd);
                bus_rvalid_i = (i != gd) && ($urandom_range(0, 1) == 1);
                bus_rdata_i  = $urandom;
                step;
            end
            bus_gnt_i = 1'b0;
            for (int j = 0; j < nwait; j++) begin
                chk("wait_bus_req", 32'(bus_req_o), 32'd0);
                chk("wait_no_resp", 32'(resp_valid_o), 32'd0);
                bus_rvalid_i = (j == rd);
                bus_rdata_i  = (j == rd) ? raw : $urandom;
                bus_gnt_i    = ($urandom_range(0, 1) == 1);
                step;
            end
            bus_rvalid_i = 1'b0;
            bus_gnt_i    = 1'b0;
        end else begin
            chk("mis_no_bus_req", 32'(bus_req_o), 32'd0);
        end
        chk("resp_valid", 32'(resp_valid_o), 32'd1);
        chk("resp_rdata", resp_rdata_o, (mis || tmo) ? 32'd0 : erd);
        chk("resp_misalign", 32'(resp_misalign_o), 32'(mis));
        chk("resp_timeout", 32'(resp_timeout_o), 32'(tmo));
        o_rdata = resp_rdata_o;
        step;
        chk("resp_one_cycle", 32'(resp_valid_o), 32'd0);
        chk("ready_again", 32'(req_ready_o), 32'd1);
    endtask

    initial begin
        logic [31:0] a, b, w, r;
        rst          = 1'b1;
        req_valid_i  = 1'b0;
        req_store_i  = 1'b0;
        req_op_i     = 3'b000;
        req_addr_i   = 32'd0;
        req_wdata_i  = 32'd0;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = 32'd0;
        step;
        step;
        chk("rst_bus_req", 32'(bus_req_o), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        chk("rst_bus_addr", bus_addr_o, 32'd0);
        chk("rst_bus_be", 32'(bus_be_o), 32'd0);
        chk("rst_resp_rdata", resp_rdata_o, 32'd0);
        rst = 1'b0;
        step;
        chk("rst_ready", 32'(req_ready_o), 32'd1);

        // LB from byte 3, sign bit set
        run_access(1'b0, 3'b110, 32'h103, 32'd0, 32'h80FF_FF7F, 0, 0, a, b, w, r);
        chk("lb_be", b, 32'h8);
        chk("lb_rdata", r, 32'hFFFF_FF80);

        // SH to upper half, acknowledged one cycle into WAIT
        run_access(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'hDEAD_BEEF, 0, 1, a, b, w, r);
        chk("sh_addr", a, 32'h200);
        chk("sh_be", b, 32'hC);
        chk("sh_wdata", w, 32'hABCD_ABCD);
        chk("sh_rdata", r, 32'd0);

        // misaligned word load
        run_access(1'b0, 3'b000, 32'h006, 32'd0, 32'h5555_5555, 0, 0, a, b, w, r);
        chk("lw_mis_rdata", r, 32'd0);

        // LHU with grant withheld 5 cycles
        run_access(1'b0, 3'b101, 32'h10, 32'd0, 32'h0000_8001, 5, 0, a, b, w, r);
        chk("lhu_rdata", r, 32'h0000_8001);

        // no rvalid at all -> timeout
        run_access(1'b0, 3'b000, 32'h20, 32'd0, 32'd0, 0, TO + 3, a, b, w, r);

        // stray bus handshakes while idle
        bus_rvalid_i = 1'b1;
        bus_gnt_i    = 1'b1;
        bus_rdata_i  = 32'hFFFF_FFFF;
        step;
        bus_rvalid_i = 1'b0;
        bus_gnt_i    = 1'b0;
        chk("stray_no_resp", 32'(resp_valid_o), 32'd0);
        chk("stray_no_bus_req", 32'(bus_req_o), 32'd0);
        chk("stray_ready", 32'(req_ready_o), 32'd1);

        // reset during REQ drops the bus request at once
        req_valid_i = 1'b1;
        req_store_i = 1'b1;
        req_op_i    = 3'b000;
        req_addr_i  = 32'h40;
        req_wdata_i = 32'hCAFE_F00D;
        step;
        req_valid_i = 1'b0;
        chk("abort_req_up", 32'(bus_req_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_req_drop", 32'(bus_req_o), 32'd0);
        chk("abort_req_addr", bus_addr_o, 32'd0);
        chk("abort_req_we", 32'(bus_we_o), 32'd0);
        step;
        rst = 1'b0;
        step;

        // reset during WAIT; late rvalid for the aborted access is ignored
        req_valid_i = 1'b1;
        req_store_i = 1'b0;
        req_op_i    = 3'b000;
        req_addr_i  = 32'h80;
        step;
        req_valid_i = 1'b0;
        bus_gnt_i   = 1'b1;
        step;
        bus_gnt_i = 1'b0;
        chk("abort_wait_in_wait", 32'(req_ready_o), 32'd0);
        rst = 1'b1;
        #1;
        chk("abort_wait_no_resp", 32'(resp_valid_o), 32'd0);
        chk("abort_wait_rdata", resp_rdata_o, 32'd0);
        step;
        rst          = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h1234_5678;
        step;
        bus_rvalid_i = 1'b0;
        chk("late_rvalid_ignored", 32'(resp_valid_o), 32'd0);
        chk("after_abort_ready", 32'(req_ready_o), 32'd1);
        run_access(1'b0, 3'b111, 32'h85, 32'd0, 32'hA1B2_C3D4, 1, 2, a, b, w, r);
        chk("post_reset_lbu", r, 32'h0000_00C3);

        // random accesses
        for (int k = 0; k < 60; k++) begin
            run_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                       $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, TO + 1)),
                       a, b, w, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_bus_master.md
LSU_BUS_MASTER -- requirements
Module: lsu_bus_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max cycles spent waiting for bus_rvalid_i before an error response.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid_i  input  1  pipeline access request valid.
REQ-005 req_ready_o  output  1  unit can accept a request (high only in IDLE).
REQ-006 req_store_i  input  1  1 = store, 0 = load.
REQ-007 req_op_i  input  3  MemOp: 000 word, 001 SH, 010 SB, 100 LH, 101 LHU, 110 LB, 111 LBU.
REQ-008 req_addr_i  input  32  byte address.
REQ-009 req_wdata_i  input  32  store data, right-aligned.
REQ-010 resp_valid_o  output  1  one-cycle completion pulse.
REQ-011 resp_rdata_o  output  32  extended load data (0 for stores and faults).
REQ-012 resp_misalign_o  output  1  access faulted on alignment, qualified by resp_valid_o.
REQ-013 resp_timeout_o  output  1  bus did not answer, qualified by resp_valid_o.
REQ-014 bus_req_o  output  1  bus request, held until granted.
REQ-015 bus_we_o  output  1  bus write.
REQ-016 bus_addr_o  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-017 bus_be_o  output  4  byte-lane enables.
REQ-018 bus_wdata_o  output  32  lane-aligned write data.
REQ-019 bus_gnt_i  input  1  memory accepted the request this cycle.
REQ-020 bus_rvalid_i  input  1  read data valid / write acknowledge.
REQ-021 bus_rdata_i  input  32  raw word from memory.

Function
REQ-022 FSM states: IDLE, REQ, WAIT, RESP; any other encoding returns to IDLE.
REQ-023 IDLE: on req_valid_i && req_ready_o, register store, op, addr, wdata; aligned -> REQ, misaligned -> RESP with misalign set.
REQ-024 Misaligned: word op with addr[1:0]!=0, half op (001/100/101) with addr[0]=1; no bus access issued.
REQ-025 Ops invalid for the direction (store with op 1xx, load with 001/010) are treated as word accesses.
REQ-026 Byte enables: word 1111; half addr[1]?1100:0011; byte 0001<<addr[1:0].
REQ-027 Write data: byte replicated to all 4 lanes, half replicated to both halves, word unchanged.
REQ-028 REQ: bus_req_o=1 with stable addr/we/be/wdata; bus_gnt_i -> WAIT; otherwise remain in REQ indefinitely.
REQ-029 WAIT: bus_req_o=0; bus_rvalid_i -> RESP, capturing rdata; counter reaching TIMEOUT_CYCLES -> RESP with timeout set.
REQ-030 Load extraction: byte lane selected by addr[1:0], half lane by addr[1]; sign-extend for LB/LH, zero-extend for LBU/LHU, pass through for word.
REQ-031 RESP: resp_valid_o=1 for exactly one cycle, then IDLE; no backpressure on the response.
REQ-032 Latency: request accepted in cycle N; bus_req_o high in N+1; with immediate gnt and rvalid in N+2, resp_valid_o high in N+3.
REQ-033 bus_rvalid_i outside WAIT is ignored; bus_gnt_i outside REQ is ignored.
REQ-034 Timeout counter clears on entry to WAIT and saturates at TIMEOUT_CYCLES.
REQ-035 Only one outstanding access exists at any time; req_ready_o=0 outside IDLE.

Reset
REQ-036 rst high forces IDLE immediately, regardless of clk; all outputs except req_ready_o become 0, req_ready_o=1 after release, and all registers and counter clear.
REQ-037 Reset mid-access drops bus_req_o the same instant; any later rvalid for the aborted access is ignored.

Verification
REQ-038 LB addr 0x103, bus_rdata 0x80FF_FF7F, immediate gnt/rvalid -> be 1000, resp_rdata 0xFFFF_FF80 in cycle N+3.
REQ-039 SH addr 0x202, wdata 0x1234_ABCD -> bus_addr 0x200, be 1100, bus_wdata 0xABCD_ABCD, we=1; resp_valid after rvalid ack with rdata 0.
REQ-040 LW addr 0x006 -> no bus_req_o; resp_valid with misalign=1 one cycle after acceptance.
REQ-041 gnt withheld 5 cycles -> bus_req_o and bus signals stable for all 5 cycles; LHU addr 0x10, rdata 0x0000_8001 -> 0x0000_8001.
REQ-042 TIMEOUT_CYCLES=4, no rvalid -> resp_valid with timeout=1 exactly 4 cycles after entering WAIT.
REQ-043 rst asserted during WAIT -> IDLE immediately, outputs cleared; next request completes normally.
